puf_challenge_sequencer: RTL and testbench

//  Downstream controller for the two ring-oscillator banks, their 32:1 muxes and edge counters.
//  It runs one measurement per response bit:

---
 rtl/puf_pkg.sv | 23 ++
 rtl/puf_window_timer.sv | 27 ++
 rtl/puf_challenge_sequencer.sv | 154 +++++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF challenge/response sequencer.
package puf_pkg;

  localparam int unsigned CHAL_W = 5;
  localparam int unsigned NUM_RO = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    SETTLE,
    COMPARE,
    VALID
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/puf_window_timer.sv
// Loadable down-counter timing the CLEAR, RUN and SETTLE phases; done flags the final cycle.
module puf_window_timer #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_len,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Parks at zero once a phase has expired so done cannot re-fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_len;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Challenge/response sequencer: one clear/window/settle/compare measurement per response bit.
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int unsigned RESP_BITS     = 8,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned CLEAR_CYCLES  = 2,
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHAL_W-1:0]    challenge,
  output logic                 busy,
  output logic                 ro_en,
  output logic                 cnt_clr,
  output logic [CHAL_W-1:0]    sel_a,
  output logic [CHAL_W-1:0]    sel_b,
  input  logic [CNT_W-1:0]     count_a,
  input  logic [CNT_W-1:0]     count_b,
  output logic [RESP_BITS-1:0] resp_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_tie
);

  localparam int unsigned MAX_LEN = max3(CLEAR_CYCLES, WINDOW_CYCLES, SETTLE_CYCLES);
  localparam int unsigned TW      = $clog2(MAX_LEN + 1);
  localparam int unsigned KW      = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  localparam logic [TW-1:0] LEN_CLR = TW'(CLEAR_CYCLES);
  localparam logic [TW-1:0] LEN_WIN = TW'(WINDOW_CYCLES);
  localparam logic [TW-1:0] LEN_SET = TW'(SETTLE_CYCLES);

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_load;
  logic [TW-1:0]          w_len;
  logic                   w_done;
  logic                   w_last;
  logic [KW-1:0]          r_k;
  logic [CHAL_W-1:0]      r_base;
  logic [CHAL_W-1:0]      r_sel;
  logic [RESP_BITS-1:0]   r_resp;
  logic                   r_tie;

  puf_window_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_len  (w_len),
    .o_done (w_done)
  );

  assign w_last = (r_k == KW'(RESP_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs decode the state directly so an async reset drops ro_en/cnt_clr at once.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_len      = '0;
    busy       = 1'b1;
    ro_en      = 1'b0;
    cnt_clr    = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = CLEAR;
          w_load = 1'b1;
          w_len  = LEN_CLR;
        end
      end
      CLEAR: begin
        cnt_clr = 1'b1;
        if (w_done) begin
          w_next = RUN;
          w_load = 1'b1;
          w_len  = LEN_WIN;
        end
      end
      RUN: begin
        ro_en = 1'b1;
        if (w_done) begin
          w_next = SETTLE;
          w_load = 1'b1;
          w_len  = LEN_SET;
        end
      end
      SETTLE: begin
        if (w_done) begin
          w_next = COMPARE;
        end
      end
      COMPARE: begin
        if (w_last) begin
          w_next = VALID;
        end else begin
          w_next = CLEAR;
          w_load = 1'b1;
          w_len  = LEN_CLR;
        end
      end
      VALID: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k    <= '0;
      r_base <= '0;
      r_sel  <= '0;
      r_resp <= '0;
      r_tie  <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_k    <= '0;
      r_base <= challenge;
      r_sel  <= challenge;
      r_resp <= '0;
      r_tie  <= 1'b0;
    end else if (r_state == COMPARE) begin
      r_resp[r_k] <= (count_a > count_b);
      r_tie       <= r_tie | (count_a == count_b);
      if (!w_last) begin
        r_k   <= r_k + 1'b1;
        r_sel <= r_base + CHAL_W'(r_k) + CHAL_W'(1);
      end
    end
  end

  assign sel_a     = r_sel;
  assign sel_b     = r_sel;
  assign resp_data = r_resp;
  assign resp_tie  = r_tie;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench: behavioural oscillator/counter model, queued expected responses and select sequences.
module tb_puf_challenge_sequencer;

  localparam int unsigned RB  = 8;
  localparam int unsigned WIN = 1024;
  localparam int unsigned PER = 2 + WIN + 4 + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  challenge = '0;
  logic        busy, ro_en, cnt_clr, resp_valid, resp_tie;
  logic [4:0]  sel_a, sel_b;
  logic [31:0] count_a = '0;
  logic [31:0] count_b = '0;
  logic [7:0]  resp_data;
  logic        resp_ready = 1'b1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int unsigned rate_a[32];
  int unsigned rate_b[32];

  typedef struct {
    logic [7:0] data;
    logic       tie;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] sel_q[$];

  puf_challenge_sequencer #(
    .RESP_BITS    (RB),
    .CNT_W        (32),
    .CLEAR_CYCLES (2),
    .WINDOW_CYCLES(WIN),
    .SETTLE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .challenge (challenge),
    .busy      (busy),
    .ro_en     (ro_en),
    .cnt_clr   (cnt_clr),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .count_a   (count_a),
    .count_b   (count_b),
    .resp_data (resp_data),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_tie  (resp_tie)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Oscillator banks: each enabled cycle adds the selected ring's rate to its counter.
  always @(negedge clk) begin
    if (cnt_clr) begin
      count_a = '0;
      count_b = '0;
    end else if (ro_en) begin
      count_a = count_a + rate_a[sel_a];
      count_b = count_b + rate_b[sel_b];
    end
  end

  logic        prev_ro = 1'b0;
  int unsigned run_len = 0;
  logic [4:0]  cur_sel = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ro = 1'b0;
      run_len = 0;
    end else begin
      if (ro_en && !prev_ro) begin
        if (sel_q.size() == 0) begin
          chk("unexpected_ro_en", 1, 0);
        end else begin
          cur_sel = sel_q.pop_front();
          chk("sel_a", sel_a, cur_sel);
          chk("sel_b", sel_b, cur_sel);
        end
        run_len = 0;
      end
      if (ro_en) run_len++;
      if (!ro_en && prev_ro) begin
        chk("window_len", run_len, WIN);
        chk("sel_hold", sel_a, cur_sel);
      end
      if (ro_en && cnt_clr) chk("ro_en_with_clr", 1, 0);
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_data", resp_data, e.data);
          chk("resp_tie", resp_tie, e.tie);
        end
      end
      prev_ro = ro_en;
    end
  end

  function automatic exp_t model(input int unsigned ch);
    exp_t e;
    e.data = '0;
    e.tie  = 1'b0;
    for (int unsigned k = 0; k < RB; k++) begin
      int unsigned idx, a, b;
      idx = (ch + k) % 32;
      a = rate_a[idx] * WIN;
      b = rate_b[idx] * WIN;
      e.data[k] = (a > b);
      if (a == b) e.tie = 1'b1;
    end
    return e;
  endfunction

  task automatic push_expected(input int unsigned ch, output exp_t e);
    e = model(ch);
    exp_q.push_back(e);
    for (int unsigned k = 0; k < RB; k++) sel_q.push_back(5'((ch + k) % 32));
  endtask

  task automatic set_a_gt_b(input int unsigned idx);
    rate_b[idx] = $urandom_range(0, 60);
    rate_a[idx] = rate_b[idx] + $urandom_range(1, 60);
  endtask

  task automatic set_a_lt_b(input int unsigned idx);
    rate_a[idx] = $urandom_range(0, 60);
    rate_b[idx] = rate_a[idx] + $urandom_range(1, 60);
  endtask

  task automatic issue_start(input logic [4:0] ch);
    int unsigned n;
    n = 0;
    while (busy && n < 20000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("idle_before_start", busy, 0);
    challenge = ch;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_valid();
    int unsigned n;
    n = 1;
    while (!resp_valid && n < 20000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("valid_latency", n, RB * PER + 1);
  endtask

  task automatic run_one(input logic [4:0] ch);
    exp_t e;
    push_expected(ch, e);
    issue_start(ch);
    wait_valid();
    @(posedge clk);
    #1 chk("idle_after_consume", busy, 0);
  endtask

  initial begin
    exp_t e;
    int unsigned ch;
    int unsigned n;
    int unsigned rises;
    logic        pro;

    for (int i = 0; i < 32; i++) begin
      rate_a[i] = 0;
      rate_b[i] = 0;
    end

    // Reset held with start asserted.
    #1 rst_n = 1'b0;
    start = 1'b1;
    challenge = 5'd17;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("rst_outputs", {busy, ro_en, cnt_clr, resp_valid, resp_tie, resp_data, sel_a, sel_b},
          '0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 if (ro_en || cnt_clr || busy) n++;
    end
    chk("idle_after_reset", n, 0);

    // All rings A faster than B.
    for (int i = 0; i < 32; i++) set_a_gt_b(i);
    run_one(5'd5);

    // Wrapping challenge, A faster only on even bits.
    for (int unsigned k = 0; k < RB; k++) begin
      if (k % 2 == 0) set_a_gt_b((30 + k) % 32);
      else set_a_lt_b((30 + k) % 32);
    end
    run_one(5'd30);

    // Equal rates on bit 3.
    ch = $urandom_range(0, 31);
    for (int i = 0; i < 32; i++) set_a_gt_b(i);
    rate_a[(ch + 3) % 32] = 25;
    rate_b[(ch + 3) % 32] = 25;
    run_one(5'(ch));

    // Back-pressure: data held, starts ignored in VALID and on the completing edge.
    for (int i = 0; i < 32; i++) begin
      rate_a[i] = $urandom_range(0, 40);
      rate_b[i] = $urandom_range(0, 40);
    end
    ch = $urandom_range(0, 31);
    push_expected(ch, e);
    issue_start(5'(ch));
    resp_ready = 1'b0;
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", resp_valid, 1);
      chk("hold_data", resp_data, e.data);
      chk("hold_tie", resp_tie, e.tie);
      start = (i == 4);
      challenge = 5'd9;
      @(posedge clk);
      #1 start = 1'b0;
    end
    resp_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_handshake", busy, 0);
    chk("valid_after_handshake", resp_valid, 0);
    @(posedge clk);
    #1 chk("start_not_queued", {busy, cnt_clr}, 0);

    // Abort mid-RUN of bit 4.
    for (int i = 0; i < 32; i++) set_a_gt_b(i);
    ch = $urandom_range(0, 31);
    push_expected(ch, e);
    issue_start(5'(ch));
    rises = 0;
    pro = 1'b0;
    n = 0;
    while (rises < 5 && n < 20000) begin
      @(posedge clk);
      #1 n++;
      if (ro_en && !pro) rises++;
      pro = ro_en;
    end
    chk("reach_bit4_run", rises, 5);
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort_outputs", {ro_en, cnt_clr, busy, resp_valid}, 0);
    exp_q.delete();
    sel_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 if (resp_valid || ro_en || busy || resp_tie || resp_data != 0) n++;
    end
    chk("quiet_after_abort", n, 0);
    run_one(5'(ch));

    // Fully random rates, ties likely.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 32; i++) begin
        rate_a[i] = $urandom_range(0, 6);
        rate_b[i] = $urandom_range(0, 6);
      end
      run_one(5'($urandom_range(0, 31)));
    end

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", exp_q.size() + sel_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
